// File: rtl/dcdc_pkg.sv
// Shared defaults, derived widths and helpers for the DC-DC PWM controller.
package dcdc_pkg;

    localparam int PWM_PERIOD_DEFAULT = 200;
    localparam int DUTY_MAX_DEFAULT   = 180;
    localparam int DUTY_STEP_DEFAULT  = 1;

    localparam int CNT_W  = $clog2(PWM_PERIOD_DEFAULT);
    localparam int DUTY_W = $clog2(DUTY_MAX_DEFAULT + 1);

    typedef enum logic [1:0] {
        UPD_LIMIT = 2'd0,
        UPD_RAISE = 2'd1,
        UPD_LOWER = 2'd2,
        UPD_HOLD  = 2'd3
    } upd_e;

    // Done in int so neither direction can wrap in the narrow duty register.
    function automatic int sat_add(input int value, input int step, input int ceiling);
        return (ceiling - value < step) ? ceiling : value + step;
    endfunction

    function automatic int sat_sub(input int value, input int step);
        return (value < step) ? 0 : value - step;
    endfunction

endpackage

// File: rtl/dcdc_pwm.sv
// Switching-period counter, period-end strobe and registered duty comparator.
module dcdc_pwm
    import dcdc_pkg::*;
#(
    parameter int  PWM_PERIOD = PWM_PERIOD_DEFAULT,
    parameter int  DUTY_MAX   = DUTY_MAX_DEFAULT,
    localparam int CW         = $clog2(PWM_PERIOD),
    localparam int DW         = $clog2(DUTY_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] duty,
    output logic [CW-1:0] cnt,
    output logic          period_end,
    output logic          driver
);

    assign period_end = (cnt == CW'(PWM_PERIOD - 1));

    // Driver lags cnt by one clock, so a duty loaded at period end governs
    // the whole following period starting at cnt == 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            driver <= 1'b0;
        end else begin
            driver <= (32'(cnt) < 32'(duty));
            cnt    <= period_end ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dcdc_controller.sv
// CV/CC regulation loop: one duty step per switching period, current limit first.
module dcdc_controller
    import dcdc_pkg::*;
#(
    parameter int PWM_PERIOD = PWM_PERIOD_DEFAULT,
    parameter int DUTY_MAX   = DUTY_MAX_DEFAULT,
    parameter int DUTY_STEP  = DUTY_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] voltageSet,
    input  logic [15:0] currentSet,
    input  logic [23:0] DCDC_VSense,
    input  logic [23:0] DCDC_CSense,
    output logic        DCDC_Driver,
    output logic        DCDC_CV
);

    localparam int CW = $clog2(PWM_PERIOD);
    localparam int DW = $clog2(DUTY_MAX + 1);

    logic [15:0]   vfb;
    logic [15:0]   ifb;
    logic [7:0]    unused_sense_lsb;
    logic [CW-1:0] cnt;
    logic          period_end;
    logic [DW-1:0] duty;
    logic [DW-1:0] duty_inc;
    logic [DW-1:0] duty_dec;
    upd_e          upd;

    assign vfb              = DCDC_VSense[23:8];
    assign ifb              = DCDC_CSense[23:8];
    assign unused_sense_lsb = DCDC_VSense[7:0] ^ DCDC_CSense[7:0];

    dcdc_pwm #(
        .PWM_PERIOD (PWM_PERIOD),
        .DUTY_MAX   (DUTY_MAX)
    ) u_pwm (
        .clk        (clk),
        .rst        (rst),
        .duty       (duty),
        .cnt        (cnt),
        .period_end (period_end),
        .driver     (DCDC_Driver)
    );

    // Equal current is still inside the limit; only strictly above trips CC.
    always_comb begin
        upd = UPD_HOLD;
        if (ifb > currentSet) begin
            upd = UPD_LIMIT;
        end else if (vfb < voltageSet) begin
            upd = UPD_RAISE;
        end else if (vfb > voltageSet) begin
            upd = UPD_LOWER;
        end
    end

    always_comb begin
        duty_inc = DW'(sat_add(int'(duty), DUTY_STEP, DUTY_MAX));
        duty_dec = DW'(sat_sub(int'(duty), DUTY_STEP));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty    <= '0;
            DCDC_CV <= 1'b0;
        end else if (period_end) begin
            unique case (upd)
                UPD_LIMIT: begin
                    DCDC_CV <= 1'b0;
                    duty    <= duty_dec;
                end
                UPD_RAISE: begin
                    DCDC_CV <= 1'b1;
                    duty    <= duty_inc;
                end
                UPD_LOWER: begin
                    DCDC_CV <= 1'b1;
                    duty    <= duty_dec;
                end
                UPD_HOLD: begin
                    DCDC_CV <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcdc_controller.sv
// Bench for dcdc_controller: period-level behavioural model, per-cycle compare, directed and random phases.
module tb_dcdc_controller;

    localparam int P    = 200;
    localparam int DMAX = 180;
    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] voltageSet = '0;
    logic [15:0] currentSet = '0;
    logic [23:0] DCDC_VSense = '0;
    logic [23:0] DCDC_CSense = '0;
    logic        DCDC_Driver;
    logic        DCDC_CV;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int m_pos  = 0;
    int m_duty = 0;
    int m_cv   = 0;
    int m_drv  = 0;

    dcdc_controller dut (
        .clk         (clk),
        .rst         (rst),
        .voltageSet  (voltageSet),
        .currentSet  (currentSet),
        .DCDC_VSense (DCDC_VSense),
        .DCDC_CSense (DCDC_CSense),
        .DCDC_Driver (DCDC_Driver),
        .DCDC_CV     (DCDC_CV)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position in period, duty level, mode; driver high for the first
    // duty positions of each period, seen one clock late.
    always @(posedge clk) begin : model
        int vfb;
        int ifb;
        if (rst) begin
            m_pos  = 0;
            m_duty = 0;
            m_cv   = 0;
            m_drv  = 0;
        end else begin
            m_drv = (m_pos < m_duty) ? 1 : 0;
            if (m_pos == P - 1) begin
                vfb = int'(DCDC_VSense) / 256;
                ifb = int'(DCDC_CSense) / 256;
                if (ifb > int'(currentSet)) begin
                    m_cv   = 0;
                    m_duty = (m_duty - STEP < 0) ? 0 : m_duty - STEP;
                end else if (vfb < int'(voltageSet)) begin
                    m_cv   = 1;
                    m_duty = (m_duty + STEP > DMAX) ? DMAX : m_duty + STEP;
                end else if (vfb > int'(voltageSet)) begin
                    m_cv   = 1;
                    m_duty = (m_duty - STEP < 0) ? 0 : m_duty - STEP;
                end else begin
                    m_cv = 1;
                end
            end
            m_pos = (m_pos + 1) % P;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("drv", int'(DCDC_Driver), m_drv);
            check("cv", int'(DCDC_CV), m_cv);
            check("duty", int'(dut.duty), m_duty);
            check("cnt", int'(dut.cnt), m_pos);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pos(input int pos);
        int i;
        i = 0;
        while (m_pos != pos && i < 2 * P) begin
            @(negedge clk);
            i++;
        end
        check("wait_pos", m_pos, pos);
    endtask

    // Raise duty from its present value to n, then freeze it with vfb == setpoint.
    task automatic ramp_to(input int n);
        int i;
        voltageSet  = 16'd35000;
        currentSet  = 16'd1000;
        DCDC_VSense = 24'd0;
        DCDC_CSense = 24'd0;
        i = 0;
        while (m_duty != n && i < (n + 2) * P) begin
            @(negedge clk);
            i++;
        end
        DCDC_VSense = {16'd35000, 8'h00};
        check("ramp", int'(dut.duty), n);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(negedge clk);
        check("rst_drv", int'(DCDC_Driver), 0);
        check("rst_cnt", int'(dut.cnt), 0);
        check("rst_duty", int'(dut.duty), 0);
        check("rst_cv", int'(DCDC_CV), 0);
        rst = 1'b0;
    endtask

    initial begin
        int hi;
        int i;
        int vs;

        // Reset, then all inputs zero
        rst = 1'b1;
        cycles(3);
        chk_en = 1'b1;
        check("init_drv", int'(DCDC_Driver), 0);
        check("init_cv", int'(DCDC_CV), 0);
        check("init_cnt", int'(dut.cnt), 0);
        rst = 1'b0;
        cycles(2 * P);
        check("zero_cv", int'(DCDC_CV), 1);
        check("zero_duty", int'(dut.duty), 0);

        // Ramp into saturation
        voltageSet = 16'd35000;
        currentSet = 16'd1000;
        cycles(181 * P);
        check("sat_duty", int'(dut.duty), 180);
        check("sat_cv", int'(DCDC_CV), 1);
        hi = 0;
        for (int k = 0; k < P; k++) begin
            @(negedge clk);
            if (DCDC_Driver) hi++;
        end
        check("sat_high", hi, 180);

        // Current limit trips: CC mode, duty walks down
        DCDC_CSense = 24'h040000;
        cycles(P);
        check("cc_cv", int'(DCDC_CV), 0);
        check("cc_first", int'(dut.duty), 179);
        i = 0;
        while (m_duty != 50 && i < 140 * P) begin
            @(negedge clk);
            i++;
        end
        check("cc_down50", int'(dut.duty), 50);

        // Current exactly at limit, voltage at setpoint: hold in CV
        DCDC_CSense = {16'd1000, 8'h00};
        DCDC_VSense = {16'd35000, 8'h00};
        cycles(5 * P);
        check("eq_duty", int'(dut.duty), 50);
        check("eq_cv", int'(DCDC_CV), 1);

        // Reset mid-period at cnt 100, duty 50
        wait_pos(100);
        reset_pulse();

        // Current limit floors duty at zero
        ramp_to(5);
        DCDC_CSense = 24'h040000;
        cycles(8 * P);
        check("cc_floor", int'(dut.duty), 0);
        check("cc_floor_cv", int'(DCDC_CV), 0);

        // Reset while the driver is high
        ramp_to(10);
        wait_pos(3);
        check("pre_rst_drv", int'(DCDC_Driver), 1);
        reset_pulse();

        // Overvoltage walks duty down to zero in CV mode
        ramp_to(10);
        DCDC_VSense = {16'd36000, 8'h00};
        DCDC_CSense = 24'd0;
        cycles(15 * P);
        check("ov_floor", int'(dut.duty), 0);
        check("ov_cv", int'(DCDC_CV), 1);

        // Random inputs around the thresholds, changed mid-period
        for (int k = 0; k < 15 * P; k++) begin
            if ($urandom_range(0, 99) < 3) begin
                voltageSet = 16'($urandom_range(30000, 30003));
                currentSet = 16'($urandom_range(500, 503));
                vs = int'(voltageSet) + int'($urandom_range(0, 6)) - 4;
                DCDC_VSense = {16'(vs), 8'($urandom_range(0, 255))};
                DCDC_CSense = {16'($urandom_range(498, 504)), 8'($urandom_range(0, 255))};
            end
            rst = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
